// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and defaults for the APB memory slave.
//   state_e      debug/FSM state encoding reported on the slave's state port
//   *_DEF        default bus widths and the reserved slave-ID address
//   WCNT_W       width of the per-transfer wait-state counter
package apb_mem_pkg;

  localparam int         ADDR_W_DEF  = 8;
  localparam int         DATA_W_DEF  = 8;
  localparam logic [7:0] ID_ADDR_DEF = 8'hFF;
  localparam int         WCNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WAIT   = 3'd2,
    ACCESS = 3'd3,
    ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: wait-state down-counter for one APB transfer.
//   clk, rst_n   clock, async active-low reset (count clears to 0)
//   load_i       load load_val_i (SETUP cycle)
//   dec_i        decrement by one, saturating at 0 (WAIT cycle)
//   load_val_i   wait states requested for this transfer
//   zero_o       count is zero: the transfer may complete
module apb_wait_counter
  import apb_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [WCNT_W-1:0] load_val_i,
  output logic              zero_o
);

  logic [WCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave front end for a single-port synchronous memory.
//   APB side : psel, penable, pwrite, paddr, pwdata -> prdata, pready, pslverr
//   Config   : wait_cycles (sampled in SETUP), id (returned at ID_ADDR)
//   Memory   : mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata <- mem_rdata
//              (mem_rdata has one cycle of read latency)
//   Debug    : state (IDLE/SETUP/WAIT/ACCESS/ERROR)
// Build option APB_MEM_SLAVE_WAIT_STATES_EN: when defined, a wait-state
// counter stretches each transfer by wait_cycles; otherwise every transfer
// completes in its first ACCESS cycle and wait_cycles is ignored.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(ID_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [WCNT_W-1:0] wait_cycles,
  input  logic [1:0]        id,
  output logic              mem_ce,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        state
);

  state_e st;
  logic   prev_setup_q, prev_setup_d;
  logic   cont;      // ACCESS phase is a legal continuation of a transfer
  logic   cnt_zero;
  logic   is_id;

  assign is_id = (paddr == ID_ADDR);

`ifdef APB_MEM_SLAVE_WAIT_STATES_EN
  // prev_setup only covers the first ACCESS cycle; was_wait carries legality
  // through the later cycles of a stretched transfer.
  logic was_wait_q, was_wait_d;

  apb_wait_counter u_wcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (st == SETUP),
    .dec_i      (st == WAIT),
    .load_val_i (wait_cycles),
    .zero_o     (cnt_zero)
  );

  assign was_wait_d = (st == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) was_wait_q <= 1'b0;
    else        was_wait_q <= was_wait_d;
  end

  assign cont = prev_setup_q | was_wait_q;
`else
  logic unused_wait;
  assign unused_wait = ^wait_cycles;
  assign cnt_zero    = 1'b1;
  assign cont        = prev_setup_q;
`endif

  // State is decoded combinationally; holding reset forces IDLE so every
  // strobe and response is quiet while rst_n is low.
  always_comb begin
    st = IDLE;
    if (rst_n && psel) begin
      if (!penable)  st = SETUP;
      else if (cont) st = cnt_zero ? ACCESS : WAIT;
      else           st = ERROR;
    end
  end

  assign prev_setup_d = (st == SETUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_setup_q <= 1'b0;
    else        prev_setup_q <= prev_setup_d;
  end

  // Reads strobe from SETUP onward so the registered memory data is ready
  // in the completing cycle; writes strobe only in the completing cycle so
  // an aborted transfer never touches memory.
  always_comb begin
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    case (st)
      SETUP, WAIT: mem_rden = ~pwrite & ~is_id;
      ACCESS: begin
        pready   = 1'b1;
        mem_rden = ~pwrite & ~is_id;
        mem_wren = pwrite & ~is_id;
        if (!pwrite) prdata = is_id ? DATA_W'(id) : mem_rdata;
      end
      ERROR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_ce    = mem_rden | mem_wren;
  assign mem_addr  = paddr;
  assign mem_wdata = pwdata;
  assign state     = st;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic [3:0] wait_cycles;
  logic [1:0] id;
  logic       mem_ce, mem_rden, mem_wren;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] state;

`ifdef APB_MEM_SLAVE_WAIT_STATES_EN
  localparam bit WS = 1'b1;
`else
  localparam bit WS = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int wr_pulses = 0;

  // Memory macro stand-in: registered read, write on the strobed edge.
  logic [7:0] mem [256];
  logic       mem_init = 1'b0;

  // Reference contents, updated only when a write transfer completes.
  logic [7:0] ref_mem [256];

  apb_mem_slave dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .wait_cycles(wait_cycles), .id(id), .mem_ce(mem_ce),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
      mem_init <= 1'b1;
    end else begin
      if (mem_ce && mem_wren) mem[mem_addr] <= mem_wdata;
      if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
    end
    if (mem_ce && mem_wren) wr_pulses <= wr_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #2;
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_pready", 32'(pready), 32'd0);
  endtask

  // One complete APB transfer, checked cycle by cycle against the rules:
  // N wait states -> pready only in ACCESS-phase cycle N+1.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [3:0] wc);
    int ew, p0;
    bit hit;
    logic [7:0] exp_rd;
    ew  = WS ? int'(wc) : 0;
    hit = wr && (a != 8'hFF);
    p0  = wr_pulses;
    exp_rd = wr ? 8'h00 : ((a == 8'hFF) ? {6'b0, id} : ref_mem[a]);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cycles = wc;
    #2;
    chk("setup_state", 32'(state), 32'd1);
    chk("setup_pready", 32'(pready), 32'd0);
    chk("setup_ce", 32'(mem_ce), 32'(!wr && a != 8'hFF));
    @(negedge clk);
    penable = 1'b1;
    wait_cycles = 4'($urandom_range(0, 15)); // must not affect this transfer
    for (int k = 0; k <= ew; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      chk("acc_state", 32'(state), (k < ew) ? 32'd2 : 32'd3);
      chk("acc_pready", 32'(pready), 32'(k == ew));
      chk("acc_pslverr", 32'(pslverr), 32'd0);
      chk("acc_wren", 32'(mem_wren), 32'(hit && k == ew));
      chk("acc_prdata", 32'(prdata), (k == ew) ? 32'(exp_rd) : 32'd0);
    end
    @(posedge clk);
    #1;
    if (hit) ref_mem[a] = d;
    chk("wr_pulses", 32'(wr_pulses - p0), 32'(hit));
  endtask

  initial begin
    logic [7:0] old;
    int p0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    rst_n = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'd6; pwdata = 8'd0; wait_cycles = 4'd0; id = 2'd1;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_ce", 32'(mem_ce), 32'd0);
    chk("rst_rden", 32'(mem_rden), 32'd0);
    chk("rst_prdata", 32'(prdata), 32'd0);
    repeat (2) @(negedge clk);
    psel = 1'b0; rst_n = 1'b1;
    idle();

    // directed sequence
    xfer(1'b1, 8'd6, 8'd5, 4'd0);
    xfer(1'b0, 8'd6, 8'd0, 4'd0);
    chk("rd6_model", 32'(ref_mem[6]), 32'd5);
    xfer(1'b1, 8'd5, 8'd4, 4'd5);
    xfer(1'b0, 8'd5, 8'd0, 4'd5);
    xfer(1'b1, 8'd4, 8'd3, 4'd1);
    xfer(1'b0, 8'd4, 8'd0, 4'd1);
    xfer(1'b1, 8'd3, 8'd2, 4'd3);
    xfer(1'b0, 8'd3, 8'd0, 4'd3);
    idle();
    xfer(1'b0, 8'hFF, 8'd0, 4'd0);
    xfer(1'b1, 8'hFF, 8'h77, 4'd2);
    chk("id_write_dropped", 32'(mem[8'hFF]), 32'(ref_mem[8'hFF]));

    // ACCESS with no preceding SETUP
    idle();
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd6; pwdata = 8'hAA;
    #2;
    chk("err_state", 32'(state), 32'd4);
    chk("err_pready", 32'(pready), 32'd1);
    chk("err_pslverr", 32'(pslverr), 32'd1);
    chk("err_ce", 32'(mem_ce), 32'd0);
    chk("err_prdata", 32'(prdata), 32'd0);
    idle();
    xfer(1'b0, 8'd6, 8'd0, 4'd0);

    // reset in the middle of a write
    p0 = wr_pulses; old = ref_mem[9];
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = ~old; wait_cycles = 4'd3;
    @(negedge clk);
    penable = 1'b1;
    #2;
    chk("rstmid_state", 32'(state), WS ? 32'd2 : 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wren", 32'(mem_wren), 32'd0);
    chk("rstmid_pready", 32'(pready), 32'd0);
    chk("rstmid_st", 32'(state), 32'd0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    #2;
    chk("rstrel_state", 32'(state), 32'd0);
    chk("rstmid_pulses", 32'(wr_pulses - p0), 32'd0);
    chk("rstmid_mem", 32'(mem[9]), 32'(old));
    xfer(1'b0, 8'd9, 8'd0, 4'd0);

`ifdef APB_MEM_SLAVE_WAIT_STATES_EN
    // psel dropped during WAIT aborts without writing
    p0 = wr_pulses; old = ref_mem[10];
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd10; pwdata = ~old; wait_cycles = 4'd4;
    @(negedge clk);
    penable = 1'b1;
    #2;
    chk("abort_wait", 32'(state), 32'd2);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #2;
    chk("abort_idle", 32'(state), 32'd0);
    chk("abort_pulses", 32'(wr_pulses - p0), 32'd0);
    xfer(1'b0, 8'd10, 8'd0, 4'd2);
`endif

    // randomized traffic over a small address window plus the ID address
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        id = 2'($urandom);
        idle();
      end
      xfer(1'($urandom), a, 8'($urandom), 4'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
